uart_rx_ss: RTL and testbench

//  UART receiver for the krv_c peripheral subsystem, on the receive end of the UART_TX serial link.

---
 rtl/uart_rx_ss.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_rx_ss.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ss.sv
// uart_rx_ss: UART receiver for the krv_c peripheral subsystem.
// It takes 8N1 frames from the uart_rx pin and writes them into a
// first-word-fall-through receive FIFO. It also reports framing and
// overrun errors.
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between
// the data bits and the stop bit. PARITY_ODD selects the parity sense.
// That build also has the parity_err port.
//
// Ports:
//   cpu_clk      single clock, rising edge
//   rst          synchronous, active-high reset
//   uart_rx      asynchronous serial input, idles high
//   rx_data      FIFO head byte, valid while rx_valid
//   rx_valid     FIFO not empty
//   rx_ready     pops the head when rx_valid && rx_ready
//   rx_fifo_cnt  current FIFO occupancy
//   rx_busy      receiver FSM is not idle
//   frame_err    sticky, stop bit sampled low
//   overrun_err  sticky, good byte arrived while the FIFO was full
//   parity_err   sticky, parity mismatch (UART_RX_PARITY_EN only)
//   err_clr      clears all sticky error flags
module uart_rx_ss #(
  parameter int BAUD_DIV   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                            cpu_clk,
  input  logic                            rst,
  input  logic                            uart_rx,
  output logic [7:0]                      rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_fifo_cnt,
  output logic                            rx_busy,
  output logic                            frame_err,
  output logic                            overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic                            parity_err,
`endif
  input  logic                            err_clr
);

  localparam int unsigned CW   = $clog2(BAUD_DIV);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned NW   = $clog2(FIFO_DEPTH+1);
  localparam int unsigned MID  = BAUD_DIV / 2;
  localparam logic [CW-1:0] C_V0  = CW'(MID - 1);
  localparam logic [CW-1:0] C_V1  = CW'(MID);
  localparam logic [CW-1:0] C_DEC = CW'(MID + 1);
  localparam logic [CW-1:0] C_END = CW'(BAUD_DIV - 1);
  localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] LAST_BIT = 3'd7;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  // PARITY_ODD has no effect in 8N1 builds. It is referenced here only so
  // that the parameter list stays the same in both builds.
  localparam logic [2:0] LAST_BIT = 3'(7 + (PARITY_ODD ? 0 : 0));
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t state, state_nxt;

  logic       s1, s2, rxs_d;
  logic [2:0] sync_ok;
  logic       rxs, rx_fall, vote, at_dec, at_end;
  logic [CW-1:0] cnt;
  logic       v_a, v_b;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       push_req, set_frame, do_push, pop, full;
`ifdef UART_RX_PARITY_EN
  logic       par_bad, set_par;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // sync_ok fills with ones as real line samples reach rxs_d. A line that
  // is still low after reset therefore does not look like a start edge.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      rxs_d   <= 1'b1;
      sync_ok <= '0;
    end else begin
      s1      <= uart_rx;
      s2      <= s1;
      rxs_d   <= s2;
      sync_ok <= {sync_ok[1:0], 1'b1};
    end
  end

  assign rxs     = s2;
  assign rx_fall = sync_ok[2] & rxs_d & ~rxs;
  assign at_dec  = (cnt == C_DEC);
  assign at_end  = (cnt == C_END);
  assign vote    = (v_a & v_b) | (v_a & rxs) | (v_b & rxs);

  always_ff @(posedge cpu_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    set_frame = 1'b0;
`ifdef UART_RX_PARITY_EN
    set_par   = 1'b0;
`endif
    case (state)
      IDLE:      if (rx_fall) state_nxt = START;
      START: begin
        if (at_dec && vote) state_nxt = IDLE;
        else if (at_end)    state_nxt = DATA;
      end
      DATA: begin
        if (at_end && bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY:    if (at_end) state_nxt = STOP;
`endif
      STOP: begin
        if (at_dec) begin
          if (!vote) begin
            set_frame = 1'b1;
            state_nxt = WAIT_IDLE;
          end else begin
`ifdef UART_RX_PARITY_EN
            if (par_bad) set_par  = 1'b1;
            else         push_req = 1'b1;
`else
            push_req  = 1'b1;
`endif
            state_nxt = IDLE;
          end
        end
      end
      WAIT_IDLE: if (rxs) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      cnt     <= '0;
      v_a     <= 1'b1;
      v_b     <= 1'b1;
      shreg   <= '0;
      bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      if (state == IDLE) cnt <= '0;
      else               cnt <= at_end ? '0 : cnt + 1'b1;
      if (cnt == C_V0) v_a <= rxs;
      if (cnt == C_V1) v_b <= rxs;
      if (state == DATA && at_dec) shreg <= {vote, shreg[7:1]};
      if (state == START)              bit_idx <= '0;
      else if (state == DATA && at_end) bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && at_dec) par_bad <= ^{shreg, vote} ^ PARITY_ODD;
`endif
    end
  end

  assign rx_busy  = (state != IDLE);
  assign rx_valid = (rx_fifo_cnt != '0);
  assign full     = (rx_fifo_cnt == FULL_CNT);
  assign pop      = rx_valid & rx_ready;
  // When the FIFO is full, a push in the same cycle as a pop writes the
  // slot that the pop frees.
  assign do_push  = push_req & (~full | pop);
  assign rx_data  = mem[rd_ptr];

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rx_fifo_cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   rx_fifo_cnt <= rx_fifo_cnt + 1'b1;
        2'b01:   rx_fifo_cnt <= rx_fifo_cnt - 1'b1;
        default: rx_fifo_cnt <= rx_fifo_cnt;
      endcase
    end
  end

  // A set in the same cycle as err_clr takes priority over the clear.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      if (set_frame)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (push_req && full && !pop) overrun_err <= 1'b1;
      else if (err_clr)             overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (set_par)      parity_err <= 1'b1;
      else if (err_clr) parity_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_ss.sv
module tb_uart_rx_ss;

  localparam int BD    = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  // Count of rising edges from driving the start bit to the first cycle
  // where the FIFO count is seen to change: 2 synchroniser flops, 1 edge
  // detect, then the decision at stop count 9, then the push edge.
  localparam int LAT = BD * NB + 13;

  logic       cpu_clk, rst, uart_rx, rx_ready, err_clr;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun_err;
  logic [2:0] rx_fifo_cnt;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int lat;

  uart_rx_ss #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH), .PARITY_ODD(1'b0)) dut (
    .cpu_clk     (cpu_clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_fifo_cnt (rx_fifo_cnt),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
`ifdef UART_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .err_clr     (err_clr)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    check(tag, {24'd0, rx_data}, {24'd0, exp});
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  // Drives one frame, starting right after a rising edge. stop_lo_bits > 0
  // holds the line low for that many bit-times before the high stop bit.
  task automatic send_frame(input logic [7:0] d, input int stop_lo_bits,
                            input bit pop_on_push, output int lat_o);
    logic [2:0] c0;
    c0    = rx_fifo_cnt;
    lat_o = -1;
    uart_rx = 1'b0;
    repeat (BD) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (BD) tick();
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = ^d ^ par_flip;
    repeat (BD) tick();
`endif
    if (stop_lo_bits > 0) begin
      uart_rx = 1'b0;
      repeat (stop_lo_bits * BD) tick();
    end
    uart_rx = 1'b1;
    for (int j = 1; j <= BD; j++) begin
      if (pop_on_push && j == 13) rx_ready = 1'b1;
      tick();
      if (pop_on_push && j == 13) rx_ready = 1'b0;
      if (lat_o < 0 && rx_fifo_cnt != c0) lat_o = BD * NB + j;
    end
  endtask

  initial begin
    rst = 1'b1; uart_rx = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    check("rst_valid", rx_valid, 0);
    check("rst_cnt", rx_fifo_cnt, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_oerr", overrun_err, 0);
`ifdef UART_RX_PARITY_EN
    check("rst_perr", parity_err, 0);
`endif
    rst = 1'b0;
    repeat (5) tick();

    // Single frame with latency check, then pop
    send_frame(8'hA5, 0, 1'b0, lat);
    check("t1_lat", lat, LAT);
    check("t1_valid", rx_valid, 1);
    check("t1_cnt", rx_fifo_cnt, 1);
    pop_chk("t1_data", 8'hA5);
    check("t1_cnt_pop", rx_fifo_cnt, 0);
    check("t1_valid_pop", rx_valid, 0);

    // Back-to-back frames into a full FIFO
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 0, 1'b0, lat);
    check("t2_cnt_full", rx_fifo_cnt, 4);
    check("t2_overrun", overrun_err, 1);
    check("t2_ferr", frame_err, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t2_oerr_clr", overrun_err, 0);
    send_frame(8'h06, 0, 1'b1, lat);
    check("t2_cnt_pushpop", rx_fifo_cnt, 4);
    check("t2_oerr_pushpop", overrun_err, 0);
    pop_chk("t2_pop02", 8'h02);
    pop_chk("t2_pop03", 8'h03);
    pop_chk("t2_pop04", 8'h04);
    pop_chk("t2_pop06", 8'h06);
    check("t2_cnt_empty", rx_fifo_cnt, 0);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    check("t2_pop_empty_cnt", rx_fifo_cnt, 0);
    check("t2_pop_empty_valid", rx_valid, 0);

    // Short glitch
    uart_rx = 1'b0;
    repeat (4) tick();
    uart_rx = 1'b1;
    repeat (3) tick();
    check("t3_busy_start", rx_busy, 1);
    repeat (20) tick();
    check("t3_busy_idle", rx_busy, 0);
    check("t3_cnt", rx_fifo_cnt, 0);
    check("t3_ferr", frame_err, 0);
    check("t3_oerr", overrun_err, 0);

    // Break after a frame, then a good frame
    send_frame(8'h3C, 40, 1'b0, lat);
    check("t4_ferr_set", frame_err, 1);
    check("t4_cnt_break", rx_fifo_cnt, 0);
    repeat (2 * BD) tick();
    check("t4_busy_after_break", rx_busy, 0);
    send_frame(8'h7E, 0, 1'b0, lat);
    check("t4_ferr_held", frame_err, 1);
    check("t4_cnt", rx_fifo_cnt, 1);
    pop_chk("t4_data", 8'h7E);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t4_ferr_clr", frame_err, 0);

    // Reset in the middle of data bit 4
    send_frame(8'h11, 0, 1'b0, lat);
    send_frame(8'h22, 1, 1'b0, lat);
    repeat (2 * BD) tick();
    check("t5_pre_cnt", rx_fifo_cnt, 1);
    check("t5_pre_ferr", frame_err, 1);
    uart_rx = 1'b0;
    repeat (BD) tick();
    for (int i = 0; i < 4; i++) begin
      uart_rx = (i == 0 || i == 3);
      repeat (BD) tick();
    end
    uart_rx = 1'b1;
    repeat (BD / 2) tick();
    check("t5_busy_mid", rx_busy, 1);
    rst = 1'b1;
    tick();
    check("t5_rst_valid", rx_valid, 0);
    check("t5_rst_cnt", rx_fifo_cnt, 0);
    check("t5_rst_data", rx_data, 0);
    check("t5_rst_busy", rx_busy, 0);
    check("t5_rst_ferr", frame_err, 0);
    check("t5_rst_oerr", overrun_err, 0);
    rst = 1'b0;
    repeat (40) tick();
    send_frame(8'h55, 0, 1'b0, lat);
    check("t5_cnt", rx_fifo_cnt, 1);
    pop_chk("t5_data", 8'h55);

`ifdef UART_RX_PARITY_EN
    // Even parity: a bad parity bit, then a good one
    par_flip = 1'b1;
    send_frame(8'h0F, 0, 1'b0, lat);
    check("t6_perr", parity_err, 1);
    check("t6_cnt_bad", rx_fifo_cnt, 0);
    check("t6_ferr", frame_err, 0);
    par_flip = 1'b0;
    send_frame(8'h0F, 0, 1'b0, lat);
    check("t6_cnt_good", rx_fifo_cnt, 1);
    pop_chk("t6_data", 8'h0F);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t6_perr_clr", parity_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
